// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - stage-1 instruction fetch with 1-entry skid buffer and redirect squash
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] line,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_line_q, skid_line_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  // The memory is addressed straight from the registered fetch PC.
  assign imem_addr = fetch_pc_q;

  // Output mux: a redirect squashes whatever is on the wire this cycle,
  // otherwise the skid entry is older than the live memory response.
  always_comb begin
    line  = NOP_INSTR;
    pc    = resp_pc_q;
    valid = 1'b0;
    if (redirect) begin
      line  = NOP_INSTR;
      pc    = resp_pc_q;
      valid = 1'b0;
    end else if (skid_valid_q) begin
      line  = skid_line_q;
      pc    = skid_pc_q;
      valid = 1'b1;
    end else if (resp_valid_q) begin
      line  = imem_rdata;
      pc    = resp_pc_q;
      valid = 1'b1;
    end
  end

  // Next-state: redirect beats stall; a stall with a live response parks it
  // in the skid and re-presents the same fetch address so nothing is lost.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_line_d  = skid_line_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      fetch_pc_d   = redirect_pc & 32'hFFFF_FFFC;
      resp_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!stall) begin
      fetch_pc_d   = fetch_pc_q + 32'd4;
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (!skid_valid_q && resp_valid_q) begin
      skid_line_d  = imem_rdata;
      skid_pc_d    = resp_pc_q;
      skid_valid_d = 1'b1;
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_line_q  <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_line_q  <= skid_line_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
